// File: rtl/decomp_sched_pkg.sv
// Shared types and constants for the decompression job scheduler.
package decomp_sched_pkg;

   localparam int unsigned TagWidth  = 8;
   localparam int unsigned DescWidth = 195;

   localparam logic StatusOk      = 1'b0;
   localparam logic StatusTimeout = 1'b1;

   typedef struct packed {
      logic [63:0] src;
      logic [63:0] des;
      logic [34:0] comp_len;
      logic [31:0] decomp_len;
   } job_desc_t;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStart,
      StWait,
      StReport,
      StHalt
   } sched_state_e;

endpackage

// File: rtl/job_desc_fifo.sv
// Synchronous descriptor FIFO; read data is registered when an entry is popped.
module job_desc_fifo
   import decomp_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [DescWidth-1:0]     wdata_i,
   input  logic                     pop_i,
   output logic [DescWidth-1:0]     rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AddrW = $clog2(DEPTH);

   logic [DescWidth-1:0] mem_q [DEPTH];
   logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AddrW:0]       count_q;
   logic [DescWidth-1:0] rdata_q;
   logic                 do_push, do_pop;

   assign full_o  = (count_q == AddrW'(0) + (AddrW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = rdata_q;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            rdata_q  <= mem_q[rd_ptr_q];
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (!do_push && do_pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Storage needs no reset; only entries below count_q are ever read.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/decomp_job_scheduler.sv
// Queues decompression jobs and runs them one at a time through the engine.
// Optional watchdog/halt behaviour is enabled by defining DECOMP_SCHED_TIMEOUT_EN.
module decomp_job_scheduler
   import decomp_sched_pkg::*;
#(
   parameter int unsigned DEPTH          = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        job_valid_i,
   output logic        job_ready_o,
   input  logic [63:0] job_src_addr_i,
   input  logic [63:0] job_des_addr_i,
   input  logic [34:0] job_comp_len_i,
   input  logic [31:0] job_decomp_len_i,
   output logic        eng_start_o,
   output logic [63:0] eng_src_addr_o,
   output logic [63:0] eng_des_addr_o,
   output logic [34:0] eng_comp_len_o,
   output logic [31:0] eng_decomp_len_o,
   input  logic        eng_ready_i,
   input  logic        eng_idle_i,
   input  logic        eng_done_i,
   output logic        cmp_valid_o,
   input  logic        cmp_ready_i,
   output logic [7:0]  cmp_tag_o,
   output logic        cmp_status_o,
   output logic [31:0] jobs_done_o,
   output logic        halted_o
);

   job_desc_t               wdesc, rdesc;
   logic                    fifo_full, fifo_empty, push, pop;
   logic [$clog2(DEPTH):0]  unused_fifo_count;

   sched_state_e            state_q;
   logic                    eng_start_q, cmp_valid_q, eng_done_q;
   logic [TagWidth-1:0]     tag_cnt_q, cmp_tag_q;
   logic [31:0]             jobs_done_q;
   logic                    done_rise;

   assign wdesc = '{src: job_src_addr_i, des: job_des_addr_i,
                    comp_len: job_comp_len_i, decomp_len: job_decomp_len_i};

   assign job_ready_o = ~fifo_full & ~halted_o;
   assign push        = job_valid_i & job_ready_o;
   assign pop         = (state_q == StIdle) & ~fifo_empty & eng_ready_i & eng_idle_i;
   assign done_rise   = eng_done_i & ~eng_done_q;

   job_desc_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .wdata_i (wdesc),
      .pop_i   (pop),
      .rdata_o (rdesc),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (unused_fifo_count)
   );

   // The FIFO read register only changes on a pop, so it holds the engine fields
   // stable from LOAD through WAIT without an extra copy.
   assign eng_src_addr_o   = rdesc.src;
   assign eng_des_addr_o   = rdesc.des;
   assign eng_comp_len_o   = rdesc.comp_len;
   assign eng_decomp_len_o = rdesc.decomp_len;
   assign eng_start_o      = eng_start_q;
   assign cmp_valid_o      = cmp_valid_q;
   assign cmp_tag_o        = cmp_tag_q;
   assign jobs_done_o      = jobs_done_q;

`ifdef DECOMP_SCHED_TIMEOUT_EN
   logic [31:0] wd_q;
   logic        cmp_status_q, halted_q;
   logic        wd_expired;

   assign wd_expired   = (wd_q + 32'd1) >= TIMEOUT_CYCLES;
   assign cmp_status_o = cmp_status_q;
   assign halted_o     = halted_q;
`else
   logic unused_cfg;

   assign unused_cfg   = ^{TIMEOUT_CYCLES, StatusTimeout};
   assign cmp_status_o = StatusOk;
   assign halted_o     = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         eng_start_q  <= 1'b0;
         cmp_valid_q  <= 1'b0;
         cmp_tag_q    <= '0;
         tag_cnt_q    <= '0;
         jobs_done_q  <= '0;
         eng_done_q   <= 1'b0;
`ifdef DECOMP_SCHED_TIMEOUT_EN
         wd_q         <= '0;
         cmp_status_q <= StatusOk;
         halted_q     <= 1'b0;
`endif
      end else begin
         eng_done_q  <= eng_done_i;
         eng_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  state_q   <= StLoad;
                  cmp_tag_q <= tag_cnt_q;
                  tag_cnt_q <= tag_cnt_q + 1'b1;
               end
            end
            StLoad: begin
               state_q     <= StStart;
               eng_start_q <= 1'b1;
            end
            StStart: begin
               state_q <= StWait;
`ifdef DECOMP_SCHED_TIMEOUT_EN
               wd_q    <= '0;
`endif
            end
            StWait: begin
               // A done edge beats a watchdog expiry landing in the same cycle.
               if (done_rise) begin
                  state_q      <= StReport;
                  cmp_valid_q  <= 1'b1;
`ifdef DECOMP_SCHED_TIMEOUT_EN
                  cmp_status_q <= StatusOk;
               end else if (wd_expired) begin
                  state_q      <= StReport;
                  cmp_valid_q  <= 1'b1;
                  cmp_status_q <= StatusTimeout;
               end else begin
                  wd_q <= wd_q + 32'd1;
`endif
               end
            end
            StReport: begin
               if (cmp_ready_i) begin
                  cmp_valid_q <= 1'b0;
                  jobs_done_q <= jobs_done_q + 32'd1;
`ifdef DECOMP_SCHED_TIMEOUT_EN
                  state_q     <= cmp_status_q ? StHalt : StIdle;
                  halted_q    <= cmp_status_q;
`else
                  state_q     <= StIdle;
`endif
               end
            end
            StHalt: state_q <= StHalt;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_decomp_job_scheduler.sv
// Scoreboard bench for decomp_job_scheduler; timeout cases run when
// DECOMP_SCHED_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 50).
module tb_decomp_job_scheduler;
   import decomp_sched_pkg::*;

   localparam int unsigned Depth = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid, job_ready;
   logic [63:0] job_src_addr, job_des_addr;
   logic [34:0] job_comp_len;
   logic [31:0] job_decomp_len;
   logic        eng_start;
   logic [63:0] eng_src_addr, eng_des_addr;
   logic [34:0] eng_comp_len;
   logic [31:0] eng_decomp_len;
   logic        eng_ready, eng_idle, eng_done;
   logic        cmp_valid, cmp_ready;
   logic [7:0]  cmp_tag;
   logic        cmp_status;
   logic [31:0] jobs_done;
   logic        halted;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   job_desc_t   exp_desc_q[$];
   logic [7:0]  exp_tag_q[$];
   logic [7:0]  next_tag;
   logic [31:0] exp_jobs;

   always #5 clk = ~clk;

   decomp_job_scheduler #(
      .DEPTH          (Depth),
      .TIMEOUT_CYCLES (32'd50)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .job_valid_i      (job_valid),
      .job_ready_o      (job_ready),
      .job_src_addr_i   (job_src_addr),
      .job_des_addr_i   (job_des_addr),
      .job_comp_len_i   (job_comp_len),
      .job_decomp_len_i (job_decomp_len),
      .eng_start_o      (eng_start),
      .eng_src_addr_o   (eng_src_addr),
      .eng_des_addr_o   (eng_des_addr),
      .eng_comp_len_o   (eng_comp_len),
      .eng_decomp_len_o (eng_decomp_len),
      .eng_ready_i      (eng_ready),
      .eng_idle_i       (eng_idle),
      .eng_done_i       (eng_done),
      .cmp_valid_o      (cmp_valid),
      .cmp_ready_i      (cmp_ready),
      .cmp_tag_o        (cmp_tag),
      .cmp_status_o     (cmp_status),
      .jobs_done_o      (jobs_done),
      .halted_o         (halted)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic job_desc_t mk_desc();
      job_desc_t d;
      d.src        = {$urandom, $urandom};
      d.des        = {$urandom, $urandom};
      d.comp_len   = {$urandom_range(0, 7), $urandom};
      d.decomp_len = $urandom;
      return d;
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      job_valid = 1'b0;
      cmp_ready = 1'b0;
      eng_done  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_desc_q.delete();
      exp_tag_q.delete();
      next_tag = 8'd0;
      exp_jobs = 32'd0;
   endtask

   task automatic push_job(input job_desc_t d);
      job_src_addr   = d.src;
      job_des_addr   = d.des;
      job_comp_len   = d.comp_len;
      job_decomp_len = d.decomp_len;
      job_valid      = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (job_ready) begin
            tick();
            job_valid = 1'b0;
            exp_desc_q.push_back(d);
            exp_tag_q.push_back(next_tag);
            next_tag = next_tag + 8'd1;
            return;
         end
         tick();
      end
      job_valid = 1'b0;
      check("push_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_start(output int lat);
      job_desc_t d;
      lat = 0;
      while (!eng_start && lat < 500) begin
         tick();
         lat++;
      end
      if (!eng_start) begin
         check("start_timeout", 64'd0, 64'd1);
         return;
      end
      if (exp_desc_q.size() == 0) begin
         check("start_unexpected", 64'd1, 64'd0);
         return;
      end
      d = exp_desc_q.pop_front();
      check("eng_src",        eng_src_addr,   d.src);
      check("eng_des",        eng_des_addr,   d.des);
      check("eng_comp_len",   eng_comp_len,   64'(d.comp_len));
      check("eng_decomp_len", eng_decomp_len, 64'(d.decomp_len));
   endtask

   task automatic take_cmp(input logic exp_status, output logic [7:0] got_tag);
      int n = 0;
      logic [7:0] etag;
      got_tag = 8'hxx;
      while (!cmp_valid && n < 500) begin
         tick();
         n++;
      end
      if (!cmp_valid) begin
         check("cmp_timeout", 64'd0, 64'd1);
         return;
      end
      if (exp_tag_q.size() == 0) begin
         check("cmp_unexpected", 64'd1, 64'd0);
         return;
      end
      etag = exp_tag_q.pop_front();
      check("cmp_tag",    cmp_tag,    etag);
      check("cmp_status", cmp_status, exp_status);
      got_tag   = cmp_tag;
      cmp_ready = 1'b1;
      tick();
      cmp_ready = 1'b0;
      exp_jobs  = exp_jobs + 32'd1;
      check("jobs_done", jobs_done, exp_jobs);
      check("cmp_drop",  cmp_valid, 1'b0);
   endtask

   // Start is seen in the START cycle; one tick later the DUT is in WAIT.
   task automatic run_job(output logic [7:0] got_tag);
      int lat;
      wait_start(lat);
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      take_cmp(StatusOk, got_tag);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int         lat;
      int         n;
      logic [7:0] t;
      logic       saw;
      job_desc_t  d;

      job_src_addr = '0; job_des_addr = '0; job_comp_len = '0; job_decomp_len = '0;
      eng_ready = 1'b1;
      eng_idle  = 1'b1;
      do_reset();

      // Reset state
      check("rst_job_ready", job_ready, 1'b1);
      check("rst_eng_start", eng_start, 1'b0);
      check("rst_cmp_valid", cmp_valid, 1'b0);
      check("rst_jobs_done", jobs_done, 32'd0);
      check("rst_halted",    halted,    1'b0);
      check("rst_eng_src",   eng_src_addr, 64'd0);
      check("rst_cmp_tag",   cmp_tag,   8'd0);

      // Single job with fixed descriptor
      d = '{src: 64'h1000, des: 64'h8000, comp_len: 35'd5000, decomp_len: 32'd9000};
      push_job(d);
      wait_start(lat);
      check("start_lat", lat + 1, 3);
      tick();
      check("start_pulse", eng_start, 1'b0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("cmp_lat", cmp_valid, 1'b1);
      take_cmp(StatusOk, t);
      check("single_tag", t, 8'd0);

      // Backpressure with a busy engine
      do_reset();
      eng_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_job(mk_desc());
      check("bp_ready_low", job_ready, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      check("bp_no_start", eng_start, 1'b0);
      eng_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_job(t);
         check("bp_tag_order", t, 8'(i));
      end
      check("bp_ready_back", job_ready, 1'b1);
      push_job(mk_desc());
      run_job(t);

      // Stale done level carried into WAIT
      do_reset();
      push_job(mk_desc());
      wait_start(lat);
      tick();
      eng_done = 1'b1;
      tick();
      take_cmp(StatusOk, t);
      push_job(mk_desc());
      wait_start(lat);
      tick();
      for (int i = 0; i < 6; i++) tick();
      check("stale_hold", cmp_valid, 1'b0);
      eng_done = 1'b0;
      tick();
      check("stale_fall", cmp_valid, 1'b0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("stale_rise", cmp_valid, 1'b1);
      take_cmp(StatusOk, t);

      // Completion stall keeps the record stable and blocks the next start
      do_reset();
      push_job(mk_desc());
      push_job(mk_desc());
      wait_start(lat);
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("stall_valid",  cmp_valid,  1'b1);
         check("stall_tag",    cmp_tag,    8'd0);
         check("stall_status", cmp_status, 1'b0);
         check("stall_start",  eng_start,  1'b0);
         tick();
      end
      take_cmp(StatusOk, t);
      wait_start(lat);
      check("restart_lat", lat, 2);
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      take_cmp(StatusOk, t);

      // Tag wrap over 257 jobs
      do_reset();
      for (int i = 0; i < 257; i++) begin
         push_job(mk_desc());
         run_job(t);
      end
      check("wrap_tag",  t, 8'd0);
      check("wrap_jobs", jobs_done, 32'd257);

      // Reset in the middle of a job drops everything
      do_reset();
      push_job(mk_desc());
      push_job(mk_desc());
      wait_start(lat);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_desc_q.delete();
      exp_tag_q.delete();
      next_tag = 8'd0;
      exp_jobs = 32'd0;
      check("mid_rst_start", eng_start, 1'b0);
      check("mid_rst_ready", job_ready, 1'b1);
      check("mid_rst_src",   eng_src_addr, 64'd0);
      check("mid_rst_jobs",  jobs_done, 32'd0);
      saw = 1'b0;
      eng_done = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         saw = saw | eng_start | cmp_valid;
      end
      eng_done = 1'b0;
      check("mid_rst_quiet", saw, 1'b0);

`ifdef DECOMP_SCHED_TIMEOUT_EN
      // Watchdog expiry with no done edge
      do_reset();
      push_job(mk_desc());
      wait_start(lat);
      n = 0;
      while (!cmp_valid && n < 200) begin
         tick();
         n++;
      end
      check("to_lat", n, 51);
      take_cmp(StatusTimeout, t);
      check("to_halted", halted,    1'b1);
      check("to_ready",  job_ready, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      check("to_halt_hold", halted, 1'b1);
      check("to_no_start",  eng_start, 1'b0);
      do_reset();
      check("to_rst_halted", halted, 1'b0);
      check("to_rst_ready",  job_ready, 1'b1);

      // Done edge on the expiry cycle wins
      push_job(mk_desc());
      wait_start(lat);
      for (int i = 0; i < 50; i++) tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("tie_valid", cmp_valid, 1'b1);
      take_cmp(StatusOk, t);
      check("tie_halted", halted, 1'b0);
`endif

      check("sb_drained", exp_tag_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
